// File: rtl/bus_rr_scheduler_if.sv
// Packet bus between the per-driver FIFOs and the round-robin scheduler.
// The scheduler connects through master; the FIFO side connects through slave.
interface bus_rr_scheduler_if #(
  parameter int unsigned DRVRS   = 4,
  parameter int unsigned PCKG_SZ = 16
);
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [PCKG_SZ-1:0]       D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler: pops one packet from the granted FIFO, then pushes it
// to its destination driver(s), with broadcast support and a saturating drop count.
module bus_rr_scheduler #(
  parameter int unsigned DRVRS     = 4,
  parameter int unsigned PCKG_SZ   = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  bus_rr_scheduler_if.master bus,
  output logic [3:0]         grant_id,
  output logic               busy,
  output logic [7:0]         drop_cnt
);
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DEST_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d, last_q, last_d;
  logic [PCKG_SZ-1:0]  pkt_q, pkt_d, pkt_sel_c;
  logic [DRVRS-1:0]    pop_q, pop_d, push_q, push_d;
  logic [DRVRS-1:0]    winner_oh_c, push_dec_c;
  logic                drop_q, drop_d, busy_q, busy_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [ID_W-1:0]     winner_c, win_hi, win_lo;
  logic                found_hi;
  logic [DEST_W-1:0]   dest_c;

  // Rotating-priority arbiter: lowest pending index above last_q, else lowest overall.
  always_comb begin : arbiter
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = int'(DRVRS) - 1; i >= 0; i--) begin
      if (bus.pndng[i]) begin
        if (ID_W'(i) > last_q) begin
          win_hi   = ID_W'(i);
          found_hi = 1'b1;
        end else begin
          win_lo = ID_W'(i);
        end
      end
    end
    winner_c = found_hi ? win_hi : win_lo;
    winner_oh_c = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      winner_oh_c[i] = (ID_W'(i) == winner_c);
    end
  end

  // Head-packet mux for the granted driver and destination decode.
  always_comb begin : decode
    pkt_sel_c = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (ID_W'(i) == grant_q) pkt_sel_c = bus.D_pop[i*PCKG_SZ +: PCKG_SZ];
    end
    dest_c = pkt_sel_c[PCKG_SZ-1 -: DEST_W];
    push_dec_c = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (dest_c == BROADCAST) push_dec_c[i] = (ID_W'(i) != grant_q);
      else push_dec_c[i] = (dest_c == DEST_W'(i)) && (ID_W'(i) != grant_q);
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pkt_d      = pkt_q;
    pop_d      = '0;
    push_d     = '0;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.pndng) begin
          state_d = POP;
          grant_d = winner_c;
          last_d  = winner_c;
          pop_d   = winner_oh_c;
        end
      end
      POP: begin
        state_d = PUSH;
        pkt_d   = pkt_sel_c;
        push_d  = push_dec_c;
        drop_d  = (push_dec_c == '0);
      end
      PUSH: begin
        if (drop_q && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        // pndng already reflects the pop, so chain straight into the next grant.
        if (|bus.pndng) begin
          state_d = POP;
          grant_d = winner_c;
          last_d  = winner_c;
          pop_d   = winner_oh_c;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= ID_W'(DRVRS - 1);
      pkt_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pkt_q      <= pkt_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = pkt_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: FIFO models feed the bus, a monitor
// compares every pop/push against queued expectations.
module tb_bus_rr_scheduler;
  localparam int unsigned DRVRS   = 4;
  localparam int unsigned PCKG_SZ = 16;

  typedef struct packed {
    logic [DRVRS-1:0]   mask;
    logic [PCKG_SZ-1:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant_id;
  logic       busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [PCKG_SZ-1:0] fq [DRVRS][$];
  exp_t               exp_push_q[$];
  int                 exp_pop_q[$];
  logic [DRVRS-1:0]   pop_seen;

  bus_rr_scheduler_if #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ)) bus ();

  bus_rr_scheduler #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .BROADCAST(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int unsigned i = 0; i < DRVRS; i++) begin
      bus.pndng[i] = (fq[i].size() != 0);
      bus.D_pop[i*PCKG_SZ +: PCKG_SZ] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic expect_xfer(input int drv, input logic [DRVRS-1:0] mask, input logic [PCKG_SZ-1:0] data);
    exp_t e;
    exp_pop_q.push_back(drv);
    if (mask != '0) begin
      e.mask = mask;
      e.data = data;
      exp_push_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    int pend;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pend = 0;
      for (int unsigned i = 0; i < DRVRS; i++) pend += fq[i].size();
    end while ((busy || pend != 0) && n < budget);
    check({name, "_done"}, 32'(busy), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_push_q.size() + exp_pop_q.size()), 32'd0);
  endtask

  // FIFO model: a pop seen during a cycle removes the head just after that edge.
  always @(posedge clk) begin
    pop_seen = bus.pop;
    #1;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (pop_seen[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    refresh();
  end

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.pop != '0) begin
        check("pop_onehot", 32'($onehot(bus.pop)), 32'd1);
        check("pop_push_excl", 32'(bus.push), 32'd0);
        if (exp_pop_q.size() == 0) check("pop_unexpected", 32'(bus.pop), 32'd0);
        else check("pop_grant", 32'(bus.pop), 32'd1 << exp_pop_q.pop_front());
      end
      if (bus.push != '0) begin
        if (exp_push_q.size() == 0) begin
          check("push_unexpected", 32'(bus.push), 32'd0);
        end else begin
          exp_t e;
          e = exp_push_q.pop_front();
          check("push_mask", 32'(bus.push), 32'(e.mask));
          check("push_data", 32'(bus.D_push), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0;
    bus.pndng = '0;
    bus.D_pop = '0;
    repeat (2) @(negedge clk);
    check("rst_pop", 32'(bus.pop), 32'd0);
    check("rst_push", 32'(bus.push), 32'd0);
    check("rst_dpush", 32'(bus.D_push), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;

    // Single packet with latency probe
    @(negedge clk);
    fq[0].push_back(16'h02A5);
    expect_xfer(0, 4'b0100, 16'h02A5);
    refresh();
    @(negedge clk);
    check("lat_pop", 32'(bus.pop), 32'h1);
    @(negedge clk);
    check("lat_push", 32'(bus.push), 32'h4);
    check("lat_dpush", 32'(bus.D_push), 32'h02A5);
    wait_idle("single", 20, n);
    check("single_drop", 32'(drop_cnt), 32'd0);

    // Round robin: all drivers pending, two packets each
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(DRVRS); i++) begin
        logic [PCKG_SZ-1:0] d;
        d = {8'((i + 1) % 4), 8'(16 * i + r)};
        fq[i].push_back(d);
        expect_xfer(i, 4'(1 << ((i + 1) % 4)), d);
      end
    end
    refresh();
    wait_idle("rr", 100, n);
    check("rr_cycles", 32'(n), 32'd17);
    check("rr_grant", 32'(grant_id), 32'd3);

    // Broadcast from driver 1
    do_reset();
    fq[1].push_back(16'hFF3C);
    expect_xfer(1, 4'b1101, 16'hFF3C);
    refresh();
    wait_idle("bcast", 20, n);
    check("bcast_grant", 32'(grant_id), 32'd1);
    check("bcast_drop", 32'(drop_cnt), 32'd0);

    // Drops: self-addressed, then out of range, then saturation
    do_reset();
    fq[3].push_back(16'h0311);
    expect_xfer(3, 4'b0000, 16'h0311);
    refresh();
    wait_idle("drop_self", 20, n);
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
    fq[3].push_back(16'h0711);
    expect_xfer(3, 4'b0000, 16'h0711);
    refresh();
    wait_idle("drop_oor", 20, n);
    check("drop_cnt_2", 32'(drop_cnt), 32'd2);
    for (int k = 0; k < 300; k++) begin
      fq[0].push_back({8'h00, 8'(k)});
      expect_xfer(0, 4'b0000, 16'h0);
    end
    refresh();
    wait_idle("drop_sat", 700, n);
    check("drop_sat_cycles", 32'(n), 32'd601);
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // Reset asserted during PUSH, then pointer restarts at driver 0
    do_reset();
    fq[2].push_back(16'h0010);
    expect_xfer(2, 4'b0001, 16'h0010);
    refresh();
    @(negedge clk);
    @(negedge clk);
    check("mid_push_pre", 32'(bus.push), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_push_cut", 32'(bus.push), 32'd0);
    check("mid_pop_cut", 32'(bus.pop), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_dpush", 32'(bus.D_push), 32'd0);
    check("mid_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    fq[0].push_back(16'h01AA);
    fq[3].push_back(16'h02BB);
    expect_xfer(0, 4'b0010, 16'h01AA);
    expect_xfer(3, 4'b0100, 16'h02BB);
    refresh();
    wait_idle("post_rst", 30, n);
    check("post_rst_grant", 32'(grant_id), 32'd3);

    // Back-to-back: three packets queued on driver 2 only
    do_reset();
    fq[2].push_back(16'h0001);
    fq[2].push_back(16'h0102);
    fq[2].push_back(16'h0303);
    expect_xfer(2, 4'b0001, 16'h0001);
    expect_xfer(2, 4'b0010, 16'h0102);
    expect_xfer(2, 4'b1000, 16'h0303);
    refresh();
    wait_idle("b2b", 30, n);
    check("b2b_cycles", 32'(n), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
